sram_access_ctrl: RTL
=====================

Name: sram_access_ctrl

Overview:
- Sequences the MEM stage's accesses to the board's 16-bit external SRAM.
- Each 32-bit load/store from the EXE/MEM pipeline register becomes two 16-bit SRAM accesses: low half first, then high half.
- `ready` is deasserted for the duration of an access; the hazard/freeze logic inverts it to drive `freeze` on all pipeline registers.
- Sits between the EXE/MEM register outputs (`MEM_R_EN`, `MEM_W_EN`, `ALU_Res`, `Val_Rm`) and the SRAM pins.

Parameters:
- ADDR_W, 18: SRAM address width, in 16-bit halfword units.
- WAIT_CYCLES, 1: extra wait cycles per halfword phase. Legal range 0..7.
- BASE_ADDR, 1024: CPU byte address that maps to SRAM halfword 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request (`MEM_R_EN_out` of the EXE/MEM register).
- wr_en  in  1  store request (`MEM_W_EN_out`).
- address  in  32  CPU byte address (`ALU_Res_out`).
- write_data  in  32  store data (`Val_Rm_out`).
- read_data  out  32  load result, valid while ready=1 in DONE.
- ready  out  1  0 = access in progress, pipeline must freeze.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  ADDR_W  SRAM halfword address.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0 after reset.

Behaviour:
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, computed in 32 bits and truncated to ADDR_W-1 bits.
  - Low half at {word,1'b0}; high half at {word,1'b1}.
  - address[1:0] is ignored.
- FSM states: IDLE, LO, HI, DONE. Down-counter `cnt` is 3 bits.
- IDLE:
  - If rd_en|wr_en: latch address, write_data and op (rd_en wins if both are asserted; the write is dropped), load cnt=WAIT_CYCLES, go to LO.
  - Otherwise stay in IDLE.
- LO:
  - SRAM_ADDR = {word,0}.
  - Write: DQ driven with data[15:0] and SRAM_WE_N=0 for every LO cycle.
  - Read: SRAM_OE_N=0, DQ tri-stated; when cnt==0, capture DQ into read_data[15:0].
  - cnt!=0: decrement. cnt==0: reload WAIT_CYCLES and go to HI.
- HI: same as LO with {word,1}, data[31:16] and read_data[31:16]; when cnt==0, go to DONE.
- DONE: ready=1 for exactly one cycle, then IDLE unconditionally. rd_en/wr_en are still high during DONE (stale request) and must not start a new access.
- ready (combinational) = (IDLE & ~rd_en & ~wr_en) | DONE.
- Access latency: 2*(WAIT_CYCLES+1) cycles of LO+HI, plus 1 DONE cycle. For WAIT_CYCLES=1, ready is low for exactly 4 cycles after the request cycle.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE.
- Idle pin state: SRAM_WE_N=1, SRAM_OE_N=1, DQ=Z, SRAM_ADDR holds its last value.
- read_data holds its value until the next read overwrites it. Writes never modify read_data.
- Reset (asynchronous, including mid-access) forces:
  - state IDLE, cnt 0, read_data 0, SRAM_ADDR 0;
  - SRAM_WE_N 1, SRAM_OE_N 1, DQ Z;
  - latched address/data/op cleared.
  - Any partially written SRAM word is left as is, with no recovery.

Optional Feature:
- Macro: SRAM_RD_CACHE_EN.
- Defined:
  - Adds a one-entry read buffer: valid bit, ADDR_W-1 bit tag, 32-bit data.
  - On a read in IDLE whose tag matches and valid=1: ready stays 1, read_data is loaded from the buffer at the clock edge, the FSM stays in IDLE and no SRAM cycle is issued. The result is valid the following cycle.
  - A completed miss read fills the buffer and sets valid.
  - A write to a matching tag updates the buffer data at DONE. Writes to other tags leave the buffer unchanged.
  - Reset clears valid.
- Undefined: no buffer; every read takes the full FSM path.

Test Plan:
- Reset, then write 0xDEADBEEF to address 1024. Required: SRAM halfword 0 = 0xBEEF, halfword 1 = 0xDEAD; ready low for 4 cycles; WE_N low only in LO/HI.
- Read address 1024 after the above. Required: read_data=0xDEADBEEF in DONE; OE_N low in LO/HI; DQ never driven by the controller.
- Write 0x12345678 to 1028, then read 1028, with rd_en held high through DONE. Required: exactly one extra access, no spurious re-read; SRAM_ADDR sequence 2,3.
- WAIT_CYCLES=3, read. Required: ready low for 8 cycles; data sampled only on the final cycle of each phase.
- Assert rst low in the HI phase of a write. Required: immediately WE_N=1, DQ=Z, ready=1, read_data=0; the next request starts in LO.
- SRAM_RD_CACHE_EN defined: read 1024 twice. Required: the second read issues no SRAM cycle and ready never drops. After writing 0x0 to 1024, a read returns 0x0 from the buffer.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit external SRAM accesses (low half, then high half).
// Optional one-entry read buffer: define SRAM_RD_CACHE_EN.
module sram_access_ctrl #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam int unsigned WORD_W   = ADDR_W - 1;
  localparam logic [2:0]  WAIT_CNT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d, word_in;
  logic [31:0]       data_q, data_d;
  logic              rd_op_q, rd_op_d;
  logic              cache_hit, req_start;

  logic [ADDR_W-1:0] addr_d;
  logic              we_n_d, oe_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [15:0]       dq_out_q, dq_out_d;

  assign word_in   = WORD_W'((address - BASE_ADDR) >> 2);
  assign req_start = (rd_en | wr_en) & ~cache_hit;

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign ready = ((state_q == S_IDLE) & ~rd_en & ~wr_en) | cache_hit | (state_q == S_DONE);

  // State, request latch and registered SRAM pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      data_q    <= '0;
      rd_op_q   <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      data_q    <= data_d;
      rd_op_q   <= rd_op_d;
      SRAM_ADDR <= addr_d;
      SRAM_WE_N <= we_n_d;
      SRAM_OE_N <= oe_n_d;
      dq_oe_q   <= dq_oe_d;
      dq_out_q  <= dq_out_d;
    end
  end

  // Next state; a read wins over a simultaneous write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    rd_op_d = rd_op_q;
    case (state_q)
      S_IDLE: begin
        if (req_start) begin
          state_d = S_LO;
          cnt_d   = WAIT_CNT;
          word_d  = word_in;
          data_d  = write_data;
          rd_op_d = rd_en;
        end
      end
      S_LO: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          cnt_d   = WAIT_CNT;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values for the cycle we are entering; SRAM_ADDR holds outside LO/HI
  always_comb begin
    addr_d   = SRAM_ADDR;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;
    case (state_d)
      S_LO: begin
        addr_d   = {word_d, 1'b0};
        we_n_d   = rd_op_d;
        oe_n_d   = ~rd_op_d;
        dq_oe_d  = ~rd_op_d;
        dq_out_d = data_d[15:0];
      end
      S_HI: begin
        addr_d   = {word_d, 1'b1};
        we_n_d   = rd_op_d;
        oe_n_d   = ~rd_op_d;
        dq_oe_d  = ~rd_op_d;
        dq_out_d = data_d[31:16];
      end
      default: ;
    endcase
  end

`ifdef SRAM_RD_CACHE_EN
  logic              cache_valid;
  logic [WORD_W-1:0] cache_tag;
  logic [31:0]       cache_data;

  assign cache_hit = (state_q == S_IDLE) & rd_en & cache_valid & (cache_tag == word_in);

  // Filled by completed miss reads; kept coherent by writes to the same tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else if (state_q == S_DONE) begin
      if (rd_op_q) begin
        cache_valid <= 1'b1;
        cache_tag   <= word_q;
        cache_data  <= read_data;
      end else if (cache_valid && (cache_tag == word_q)) begin
        cache_data  <= data_q;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Each half is sampled only on the last wait cycle of its phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else begin
`ifdef SRAM_RD_CACHE_EN
      if (cache_hit) read_data <= cache_data;
`endif
      if (rd_op_q && (cnt_q == 3'd0)) begin
        if (state_q == S_LO)      read_data[15:0]  <= SRAM_DQ;
        else if (state_q == S_HI) read_data[31:16] <= SRAM_DQ;
      end
    end
  end

endmodule
